// File: rtl/jk_excitation_driver_if.sv
// Target handshake between lab sequencing logic (master) and jk_excitation_driver (slave).
interface jk_excitation_driver_if #(
    parameter int unsigned WIDTH = 4
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    modport master (
        output tgt_valid,
        output tgt_data,
        input  tgt_ready
    );

    modport slave (
        input  tgt_valid,
        input  tgt_data,
        output tgt_ready
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// Derives J/K excitation to move a bank of JK flip-flops to a target, verifies, retries.
// Define JKDRV_TOGGLE_EN to drive changing bits with J=K=1 instead of set/reset excitation.
module jk_excitation_driver #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jk_excitation_driver_if.slave tgt,
    input  logic [WIDTH-1:0]      q_fb,
    output logic [WIDTH-1:0]      j,
    output logic [WIDTH-1:0]      k,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int unsigned        RETRY_W     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        VERIFY = 2'd2
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
    } jk_t;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   tgt_q, tgt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [WIDTH-1:0]   j_q, j_d;
    logic [WIDTH-1:0]   k_q, k_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    jk_t                accept_jk, retry_jk;

    function automatic jk_t excite(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
        jk_t ex;
`ifdef JKDRV_TOGGLE_EN
        ex.j = q ^ t;
        ex.k = q ^ t;
`else
        ex.j = ~q & t;
        ex.k = q & ~t;
`endif
        return ex;
    endfunction

    assign accept_jk = excite(q_fb, tgt.tgt_data);
    assign retry_jk  = excite(q_fb, tgt_q);

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        retry_d = retry_q;
        j_d     = '0;
        k_d     = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tgt.tgt_valid) begin
                    tgt_d   = tgt.tgt_data;
                    retry_d = '0;
                    j_d     = accept_jk.j;
                    k_d     = accept_jk.k;
                    state_d = DRIVE;
                end
            end
            // j/k fall back to zero as the flip-flops capture them at the end of DRIVE.
            DRIVE: state_d = VERIFY;
            VERIFY: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q != RETRY_LIMIT) begin
                    retry_d = retry_q + RETRY_W'(1);
                    j_d     = retry_jk.j;
                    k_d     = retry_jk.k;
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            retry_q <= '0;
            j_q     <= '0;
            k_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            retry_q <= retry_d;
            j_q     <= j_d;
            k_q     <= k_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tgt.tgt_ready = (state_q == IDLE);
    assign busy          = (state_q != IDLE);
    assign j             = j_q;
    assign k             = k_q;
    assign done          = done_q;
    assign err           = err_q;
endmodule
